mul_exp_round_pipe: RTL and testbench

- Parametrised, pipelined exponent path for the FPU multiplier.
- Computes the biased product exponent from two operand exponents, applies the mantissa-normalisation increment and the rounding carry, and saturates to inf/zero with overflow/underflow flags.
- Two register stages with valid/ready flow control.
- Sits between the operand unpack stage and the FPU_MUL result pack stage.

---
 rtl/mul_exp_round_pipe.sv | 98 +++++++++
 tb/tb_mul_exp_round_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_exp_round_pipe.sv
// rtl/mul_exp_round_pipe.sv - two-stage FPU multiplier exponent path with round carry and saturation
module mul_exp_round_pipe #(
    parameter int EXP_W = 8,
    parameter int BIAS  = 127
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [EXP_W-1:0] i_exp_a,
    input  logic [EXP_W-1:0] i_exp_b,
    input  logic             i_norm_shift,
    input  logic             i_carry_rounding,
    input  logic             i_zero,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [EXP_W-1:0] o_exp_result,
    output logic             o_overflow,
    output logic             o_underflow
);

    // Two guard bits: one for the a+b carry, one for sign once the bias is removed.
    localparam int SW = EXP_W + 2;
    localparam logic signed [SW-1:0] EXP_MAX = SW'((1 << EXP_W) - 1);

    logic                 s1_valid;
    logic signed [SW-1:0] s1_sum;
    logic                 s1_carry;
    logic                 s1_zero;

    logic                 s2_load;
    logic                 s1_load;
    logic signed [SW-1:0] s1_sum_next;
    logic signed [SW-1:0] r;
    logic [EXP_W-1:0]     exp_next;
    logic                 ovf_next;
    logic                 unf_next;

    // Stage 2 drains whenever it is empty or its result is being taken;
    // stage 1 can then move forward, which is also when a new input fits.
    assign s2_load = !o_valid || i_ready;
    assign s1_load = !s1_valid || s2_load;
    assign o_ready = s1_load;

    assign s1_sum_next = SW'(i_exp_a) + SW'(i_exp_b) - SW'(BIAS) + SW'(i_norm_shift);
    assign r           = s1_sum + SW'(s1_carry);

    // Saturation: zero wins over both flags, then overflow, then underflow (no subnormals).
    always_comb begin
        exp_next = r[EXP_W-1:0];
        ovf_next = 1'b0;
        unf_next = 1'b0;
        if (s1_zero) begin
            exp_next = '0;
        end else if (r >= EXP_MAX) begin
            exp_next = '1;
            ovf_next = 1'b1;
        end else if (r[SW-1] || (r == '0)) begin
            exp_next = '0;
            unf_next = 1'b1;
        end
    end

    // Stage 1: biased sum plus normalisation increment, carry/zero ride alongside.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_carry <= 1'b0;
            s1_zero  <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_sum   <= s1_sum_next;
                s1_carry <= i_carry_rounding;
                s1_zero  <= i_zero;
            end
        end
    end

    // Stage 2: output register; data held while stalled, valid clears on a bubble.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid      <= 1'b0;
            o_exp_result <= '0;
            o_overflow   <= 1'b0;
            o_underflow  <= 1'b0;
        end else if (s2_load) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_exp_result <= exp_next;
                o_overflow   <= ovf_next;
                o_underflow  <= unf_next;
            end
        end
    end

endmodule

// File: tb/tb_mul_exp_round_pipe.sv
// tb/tb_mul_exp_round_pipe.sv - directed table-driven bench for mul_exp_round_pipe
module tb_mul_exp_round_pipe;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_exp_a;
    logic [7:0] i_exp_b;
    logic       i_norm_shift;
    logic       i_carry_rounding;
    logic       i_zero;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_exp_result;
    logic       o_overflow;
    logic       o_underflow;

    int checks = 0;
    int errors = 0;

    mul_exp_round_pipe #(.EXP_W(8), .BIAS(127)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .i_exp_a          (i_exp_a),
        .i_exp_b          (i_exp_b),
        .i_norm_shift     (i_norm_shift),
        .i_carry_rounding (i_carry_rounding),
        .i_zero           (i_zero),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_exp_result     (o_exp_result),
        .o_overflow       (o_overflow),
        .o_underflow      (o_underflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       norm;
        logic       carry;
        logic       zero;
        logic [7:0] exp;
        logic       ovf;
        logic       unf;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    int         accepted;
    int         out_cnt;
    logic [7:0] out_exp [4];
    int         out_cyc [4];
    int         cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b);
        i_exp_a          = a;
        i_exp_b          = b;
        i_norm_shift     = 1'b0;
        i_carry_rounding = 1'b0;
        i_zero           = 1'b0;
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        cyc = 0;
        //          a    b    n  c  z   exp  ovf unf
        vecs[0]  = '{8'd127, 8'd127, 0, 0, 0, 8'd127, 0, 0};
        vecs[1]  = '{8'd127, 8'd127, 1, 1, 0, 8'd129, 0, 0};
        vecs[2]  = '{8'd254, 8'd127, 0, 0, 0, 8'd254, 0, 0};
        vecs[3]  = '{8'd254, 8'd127, 0, 1, 0, 8'd255, 1, 0};
        vecs[4]  = '{8'd254, 8'd254, 0, 0, 0, 8'd255, 1, 0};
        vecs[5]  = '{8'd64,  8'd63,  0, 0, 0, 8'd0,   0, 1};
        vecs[6]  = '{8'd64,  8'd63,  1, 0, 0, 8'd1,   0, 0};
        vecs[7]  = '{8'd1,   8'd1,   0, 0, 0, 8'd0,   0, 1};
        vecs[8]  = '{8'd254, 8'd254, 0, 0, 1, 8'd0,   0, 0};
        vecs[9]  = '{8'd0,   8'd0,   0, 0, 0, 8'd0,   0, 1};
        vecs[10] = '{8'd255, 8'd255, 1, 1, 0, 8'd255, 1, 0};
        vecs[11] = '{8'd200, 8'd100, 0, 1, 0, 8'd174, 0, 0};
        vecs[12] = '{8'd64,  8'd63,  0, 1, 0, 8'd1,   0, 0};

        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        drive(8'd0, 8'd0);
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        check("reset_o_valid", o_valid, 0);
        check("reset_o_exp", o_exp_result, 0);
        check("reset_o_ovf", o_overflow, 0);
        check("reset_o_unf", o_underflow, 0);
        check("reset_o_ready", o_ready, 1);

        // Single transactions, unstalled: check latency and saturation results.
        for (int i = 0; i < NV; i++) begin
            @(negedge i_clk);
            i_valid          = 1'b1;
            i_exp_a          = vecs[i].a;
            i_exp_b          = vecs[i].b;
            i_norm_shift     = vecs[i].norm;
            i_carry_rounding = vecs[i].carry;
            i_zero           = vecs[i].zero;
            check($sformatf("v%0d_in_ready", i), o_ready, 1);
            @(posedge i_clk);
            #1 i_valid = 1'b0;
            @(negedge i_clk);
            check($sformatf("v%0d_valid_early", i), o_valid, 0);
            @(negedge i_clk);
            check($sformatf("v%0d_valid", i), o_valid, 1);
            check($sformatf("v%0d_exp", i), o_exp_result, vecs[i].exp);
            check($sformatf("v%0d_ovf", i), o_overflow, vecs[i].ovf);
            check($sformatf("v%0d_unf", i), o_underflow, vecs[i].unf);
        end
        @(negedge i_clk);
        check("drain_valid", o_valid, 0);

        // Backpressure: four inputs against a stalled consumer.
        i_ready  = 1'b0;
        accepted = 0;
        out_cnt  = 0;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    int guard;
                    @(negedge i_clk);
                    i_valid = 1'b1;
                    drive(8'(127 + k), 8'd127);
                    guard = 0;
                    while (!o_ready && guard < 50) begin
                        @(negedge i_clk);
                        guard++;
                    end
                    if (guard >= 50) check("bp_producer_timeout", guard, 0);
                    @(posedge i_clk);
                    accepted++;
                end
                @(negedge i_clk);
                i_valid = 1'b0;
            end
            begin
                repeat (6) begin
                    @(negedge i_clk);
                end
                check("bp_accepted_stall", accepted, 2);
                check("bp_o_ready_low", o_ready, 0);
                check("bp_valid_stall", o_valid, 1);
                check("bp_exp_stable", o_exp_result, 127);
                @(posedge i_clk);
                #1 i_ready = 1'b1;
            end
            begin
                for (int t = 0; t < 40 && out_cnt < 4; t++) begin
                    @(negedge i_clk);
                    if (o_valid && i_ready) begin
                        out_exp[out_cnt] = o_exp_result;
                        out_cyc[out_cnt] = cyc;
                        out_cnt++;
                    end
                end
            end
        join
        check("bp_out_count", out_cnt, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < out_cnt) begin
                check($sformatf("bp_out%0d_exp", k), out_exp[k], 127 + k);
                if (k > 0) check($sformatf("bp_out%0d_gap", k), out_cyc[k] - out_cyc[k-1], 1);
            end
        end
        @(negedge i_clk);
        check("bp_drained", o_valid, 0);

        // Reset with two transactions in flight.
        i_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            i_valid = 1'b1;
            drive(8'd140, 8'd127);
            @(posedge i_clk);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        check("rst_pre_valid", o_valid, 1);
        check("rst_pre_ready", o_ready, 0);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst   = 1'b0;
        i_ready = 1'b1;
        check("rst_mid_valid", o_valid, 0);
        check("rst_mid_exp", o_exp_result, 0);
        check("rst_mid_ready", o_ready, 1);
        i_valid = 1'b1;
        drive(8'd130, 8'd127);
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        @(negedge i_clk);
        check("rst_new_no_stale", o_valid, 0);
        @(negedge i_clk);
        check("rst_new_valid", o_valid, 1);
        check("rst_new_exp", o_exp_result, 130);
        @(negedge i_clk);
        check("rst_new_drained", o_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
